fm_modulator: RTL and testbench

- Transmit-side counterpart of the FM receive chain.
- Accepts signed audio samples at a low rate over a valid/ready handshake and linearly interpolates them to the system clock rate.
- Scales the interpolated audio by a programmable deviation, adds it to a carrier frequency word, and drives a phase accumulator.
- Outputs a 1-bit FM carrier (accumulator MSB) suitable for a pin or PWM-style output stage.

---
 rtl/fm_tx_pkg.sv | 20 ++
 rtl/fm_interp.sv | 78 +++++++
 rtl/fm_modulator.sv | 110 +++++++++++
 tb/tb_fm_modulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_tx_pkg.sv
// rtl/fm_tx_pkg.sv - shared types, default widths and helpers for the FM transmitter
package fm_tx_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} tx_state_t;

    localparam int PHASE_W_DEF = 32;
    localparam int AUDIO_W_DEF = 12;
    localparam int DEV_W_DEF   = 16;

    function automatic int sat_signed(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/fm_interp.sv
// rtl/fm_interp.sv - one-entry audio buffer and linear interpolator to clock rate
module fm_interp
    import fm_tx_pkg::*;
#(
    parameter int AUDIO_W     = AUDIO_W_DEF,
    parameter int INTERP_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      run,
    input  logic                      active,
    input  logic signed [AUDIO_W-1:0] audio_in,
    input  logic                      audio_valid,
    output logic                      audio_ready,
    output logic signed [AUDIO_W-1:0] interp,
    output logic                      underrun,
    output logic                      seg_last
);
    localparam int STEP_W = AUDIO_W + 1;
    localparam int ACC_W  = AUDIO_W + 1 + INTERP_LOG2;

    logic signed [AUDIO_W-1:0] buf_data;
    logic                      buf_full;
    logic signed [AUDIO_W-1:0] target;
    logic signed [STEP_W-1:0]  step;
    logic signed [STEP_W-1:0]  step_next;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_int;
    logic [INTERP_LOG2-1:0]    seg_cnt;
    logic                      primed;

    assign audio_ready = run && !buf_full;
    assign seg_last    = (seg_cnt == {INTERP_LOG2{1'b1}});
    assign acc_int     = acc >>> INTERP_LOG2;
    assign interp      = AUDIO_W'(sat_signed(int'(acc_int), AUDIO_W));
    assign step_next   = $signed({buf_data[AUDIO_W-1], buf_data})
                       - $signed({target[AUDIO_W-1], target});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buf_data <= '0;
            buf_full <= 1'b0;
            target   <= '0;
            step     <= '0;
            acc      <= '0;
            seg_cnt  <= '0;
            primed   <= 1'b0;
            underrun <= 1'b0;
        end else if (active) begin
            seg_cnt  <= seg_cnt + INTERP_LOG2'(1);
            acc      <= acc + {{INTERP_LOG2{step[STEP_W-1]}}, step};
            underrun <= 1'b0;
            if (seg_cnt == '0) begin
                // The first boundary after START can never have a sample buffered yet.
                primed <= 1'b1;
                if (run && buf_full) begin
                    step     <= step_next;
                    target   <= buf_data;
                    buf_full <= 1'b0;
                end else begin
                    step     <= '0;
                    underrun <= run && primed;
                end
            end
            if (audio_valid && audio_ready) begin
                buf_data <= audio_in;
                buf_full <= 1'b1;
            end
            if (!run) begin
                buf_full <= 1'b0;
            end
        end else begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: rtl/fm_modulator.sv
// rtl/fm_modulator.sv - FM transmitter: control FSM, deviation multiply and phase accumulator
module fm_modulator
    import fm_tx_pkg::*;
#(
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int AUDIO_W     = AUDIO_W_DEF,
    parameter int DEV_W       = DEV_W_DEF,
    parameter int INTERP_LOG2 = 8
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic                      tx_en,
    input  logic [PHASE_W-1:0]        carrier_fre,
    input  logic [DEV_W-1:0]          deviation,
    input  logic signed [AUDIO_W-1:0] audio_in,
    input  logic                      audio_valid,
    output logic                      audio_ready,
    output logic                      FM_OUT,
    output logic                      tx_active,
    output logic                      underrun
);
    localparam int PROD_W = AUDIO_W + DEV_W + 1;

    tx_state_t                 state;
    logic [PHASE_W-1:0]        carrier_l;
    logic [DEV_W-1:0]          dev_l;
    logic [PHASE_W-1:0]        fw;
    logic [PHASE_W-1:0]        phase;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  prod_sh;
    logic signed [PROD_W-1:0]  interp_x;
    logic signed [PROD_W-1:0]  dev_x;
    logic signed [AUDIO_W-1:0] interp;
    logic                      seg_last;
    logic                      start;
    logic                      run;
    logic                      active;

    assign start    = (state == START);
    assign run      = (state == RUN);
    assign active   = run || (state == STOP);
    assign interp_x = {{(PROD_W-AUDIO_W){interp[AUDIO_W-1]}}, interp};
    assign dev_x    = {{(PROD_W-DEV_W){1'b0}}, dev_l};
    assign prod_sh  = prod >>> (AUDIO_W - 1);

    fm_interp #(
        .AUDIO_W     (AUDIO_W),
        .INTERP_LOG2 (INTERP_LOG2)
    ) u_interp (
        .clk         (clk_in),
        .rst         (RST),
        .clear       (start),
        .run         (run),
        .active      (active),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .interp      (interp),
        .underrun    (underrun),
        .seg_last    (seg_last)
    );

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state     <= IDLE;
            tx_active <= 1'b0;
            carrier_l <= '0;
            dev_l     <= '0;
            prod      <= '0;
            fw        <= '0;
            phase     <= '0;
            FM_OUT    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_en) state <= START;
                end
                START: begin
                    carrier_l <= carrier_fre;
                    dev_l     <= deviation;
                    tx_active <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (!tx_en) state <= STOP;
                end
                STOP: begin
                    if (seg_last) begin
                        state     <= IDLE;
                        tx_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Pipeline and phase run only while transmitting; leaving STOP parks them at zero.
            if (active && !(state == STOP && seg_last)) begin
                prod   <= interp_x * dev_x;
                fw     <= carrier_l + {{(PHASE_W-PROD_W){prod_sh[PROD_W-1]}}, prod_sh};
                phase  <= phase + fw;
                FM_OUT <= phase[PHASE_W-1];
            end else begin
                prod   <= '0;
                fw     <= '0;
                phase  <= '0;
                FM_OUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fm_modulator.sv
// tb/tb_fm_modulator.sv - randomized scoreboard bench for fm_modulator
`timescale 1ns/1ps
module tb_fm_modulator;
    localparam int L   = 2;
    localparam int SEG = 1 << L;
    localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_STOP = 3;

    logic              clk_in = 1'b0;
    logic              RST;
    logic              tx_en;
    logic [31:0]       carrier_fre;
    logic [15:0]       deviation;
    logic signed [11:0] audio_in;
    logic              audio_valid;
    logic              audio_ready;
    logic              FM_OUT;
    logic              tx_active;
    logic              underrun;

    fm_modulator #(
        .PHASE_W     (32),
        .AUDIO_W     (12),
        .DEV_W       (16),
        .INTERP_LOG2 (L)
    ) dut (
        .clk_in      (clk_in),
        .RST         (RST),
        .tx_en       (tx_en),
        .carrier_fre (carrier_fre),
        .deviation   (deviation),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .FM_OUT      (FM_OUT),
        .tx_active   (tx_active),
        .underrun    (underrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        fm;
        logic        act;
        logic        rdy;
        logic        und;
        logic [31:0] fw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: targets per segment, linear ramp between them, phase as a running sum.
    int          m_mode = M_IDLE;
    int          m_n = 0;
    logic [31:0] m_car = '0;
    int          m_dev = 0;
    int          m_buf[$];
    int          m_tgt[$];
    logic [31:0] m_phase = '0;
    logic        m_fm = 1'b0;
    logic        m_und = 1'b0;

    // Stimulus source
    int                 src[$];
    logic               offering = 1'b0;
    logic               rand_src = 1'b0;
    logic signed [11:0] cur_smp = '0;
    logic signed [11:0] hold_val = '0;

    function automatic int interp_at(input int n);
        int m, s, k, prev, cur;
        if (n < 1) return 0;
        m    = n - 1;
        s    = m / SEG;
        k    = m % SEG;
        prev = (s > 0) ? m_tgt[s-1] : 0;
        cur  = m_tgt[s];
        return ((prev * SEG) + (cur - prev) * k) >>> L;
    endfunction

    function automatic logic [31:0] fw_at(input int n);
        longint p;
        if (n == 0) return 32'h0;
        p = longint'(interp_at(n - 2)) * longint'(m_dev);
        return m_car + 32'(p >>> 11);
    endfunction

    task automatic model_advance(input logic rst, input logic tx, input logic take,
                                 input logic signed [11:0] smp);
        logic fm_next;
        logic und_next;
        if (rst) begin
            m_mode = M_IDLE; m_fm = 1'b0; m_und = 1'b0; m_phase = '0;
            m_buf.delete();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (tx) m_mode = M_START;
            end
            M_START: begin
                m_car = carrier_fre; m_dev = int'(deviation);
                m_n = 0; m_phase = '0; m_fm = 1'b0; m_und = 1'b0;
                m_buf.delete(); m_tgt.delete();
                m_mode = M_RUN;
            end
            default: begin
                und_next = 1'b0;
                if (m_n % SEG == 0) begin
                    if (m_mode == M_RUN && m_buf.size() > 0) begin
                        m_tgt.push_back(m_buf.pop_front());
                    end else begin
                        m_tgt.push_back(m_tgt.size() > 0 ? m_tgt[$] : 0);
                        und_next = (m_mode == M_RUN) && (m_n > 0);
                    end
                end
                if (take) m_buf.push_back(int'(smp));
                if (m_mode == M_STOP) m_buf.delete();
                fm_next = m_phase[31];
                m_phase = m_phase + fw_at(m_n);
                if (m_mode == M_STOP && m_n % SEG == SEG - 1) begin
                    m_mode = M_IDLE; m_fm = 1'b0; m_phase = '0; m_und = 1'b0;
                end else begin
                    m_fm  = fm_next;
                    m_und = und_next;
                    if (m_mode == M_RUN && !tx) m_mode = M_STOP;
                    m_n++;
                end
            end
        endcase
    endtask

    task automatic step_cycle(input logic rst, input logic tx, input logic valid,
                              input logic signed [11:0] smp, output logic rdy);
        exp_t e;
        RST = rst; tx_en = tx; audio_valid = valid; audio_in = smp;
        rdy   = (m_mode == M_RUN) && (m_buf.size() == 0);
        e.act = (m_mode == M_RUN) || (m_mode == M_STOP);
        e.rdy = rdy;
        e.fm  = m_fm;
        e.und = m_und;
        e.fw  = e.act ? fw_at(m_n) : 32'h0;
        exp_q.push_back(e);
        model_advance(rst, tx, valid && rdy, smp);
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_cycles(input int ncyc, input int p_valid, input logic tx);
        logic rdy;
        for (int i = 0; i < ncyc; i++) begin
            if (!offering && int'($urandom_range(99)) < p_valid) begin
                offering = 1'b1;
                if (src.size() > 0)  cur_smp = 12'(src.pop_front());
                else if (rand_src)   cur_smp = 12'($urandom);
                else                 cur_smp = hold_val;
            end
            step_cycle(1'b0, tx, offering, offering ? cur_smp : 12'sh0, rdy);
            if (offering && rdy) offering = 1'b0;
        end
    endtask

    task automatic stop_to_idle(input int p_valid);
        for (int k = 0; k < SEG && (m_n % SEG) != 1; k++) run_cycles(1, p_valid, 1'b1);
        run_cycles(SEG + 2, p_valid, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("FM_OUT", 32'(FM_OUT), 32'(e.fm));
            chk("tx_active", 32'(tx_active), 32'(e.act));
            chk("audio_ready", 32'(audio_ready), 32'(e.rdy));
            chk("underrun", 32'(underrun), 32'(e.und));
            chk("fw", dut.fw, e.fw);
        end
    end

    initial begin
        logic rdy;
        RST = 1'b1; tx_en = 1'b0; audio_valid = 1'b0; audio_in = '0;
        carrier_fre = '0; deviation = '0;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b0, 1'b0, 12'sh0, rdy);

        // Carrier only
        carrier_fre = 32'h4000_0000; deviation = 16'h0000; hold_val = 12'sd0;
        run_cycles(24, 100, 1'b1);
        stop_to_idle(100);

        // Interpolation 0 -> 400
        carrier_fre = 32'h0100_0000; deviation = 16'h0800;
        src = '{0, 400}; hold_val = 12'sd400;
        run_cycles(20, 100, 1'b1);
        stop_to_idle(100);

        // Full scale positive then negative
        carrier_fre = 32'h2000_0000; deviation = 16'h1000; hold_val = 12'sd2047;
        run_cycles(16, 100, 1'b1);
        hold_val = -12'sd2048;
        run_cycles(16, 100, 1'b1);
        stop_to_idle(100);

        // Underrun and re-fill
        hold_val = 12'sd300;
        run_cycles(10, 100, 1'b1);
        run_cycles(12, 0, 1'b1);
        run_cycles(12, 100, 1'b1);
        stop_to_idle(0);

        // Randomized rounds with register churn mid-run and a mid-run reset
        rand_src = 1'b1;
        for (int r = 0; r < 4; r++) begin
            carrier_fre = $urandom; deviation = 16'($urandom);
            run_cycles(40, 60, 1'b1);
            carrier_fre = $urandom; deviation = 16'($urandom);
            run_cycles(20, 80, 1'b1);
            if (r % 2 == 1) begin
                carrier_fre = $urandom;
                step_cycle(1'b1, 1'b1, 1'b0, 12'sh0, rdy);
                offering = 1'b0;
                run_cycles(30, 70, 1'b1);
            end
            stop_to_idle(50);
            run_cycles(3, 50, 1'b0);
        end

        @(negedge clk_in);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: actual=%0d required=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
